// File: rtl/bk_pkg.sv
// -----------------------------------------------------------------------------
// bk_pkg
// Shared definitions for the backup-RAM sector controller: default geometry
// constants and the controller state encoding.
// -----------------------------------------------------------------------------
package bk_pkg;

   // Default sectors per save slot (power of two, at least 2)
   localparam int BK_SECTORS_DEF = 64;
   // Default slot-select width
   localparam int BK_SLOT_W_DEF  = 2;
   // Default acknowledge-timeout counter width
   localparam int BK_TMO_W_DEF   = 24;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_XFER = 3'd2,
      ST_NEXT = 3'd3,
      ST_FIN  = 3'd4
   } bk_state_t;

endpackage

// File: rtl/bk_timeout.sv
// -----------------------------------------------------------------------------
// bk_timeout
// Clear / enable / expire counter guarding the wait for an HPS acknowledge.
//
// Ports:
//   clk_sys  in  system clock
//   RESET_n  in  asynchronous active-low reset
//   clr      in  restart the count from zero (wins over en)
//   en       in  count this cycle
//   expired  out high in the cycle whose increment brings the count to
//                all-ones, so the owner can abort on that same edge
// -----------------------------------------------------------------------------
module bk_timeout #(
   parameter int TMO_W = 24
) (
   input  logic clk_sys,
   input  logic RESET_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   // All-ones minus one: the value from which the next increment saturates
   localparam logic [TMO_W-1:0] CNT_LAST = ~TMO_W'(1);

   logic [TMO_W-1:0] cnt;

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + TMO_W'(1);
      end
   end

   assign expired = en & ~clr & (cnt == CNT_LAST);

endmodule

// File: rtl/bk_sector_ctrl.sv
// -----------------------------------------------------------------------------
// bk_sector_ctrl
// Moves one save slot (SECTORS sectors) between the core's state RAM and the
// HPS-mounted save image, one sector request at a time.
//
// Ports:
//   clk_sys   in   system clock
//   RESET_n   in   asynchronous active-low reset
//   bk_ena    in   writable save image mounted; low blocks new requests
//   load_req  in   load-state level, acted on at its rising edge
//   save_req  in   save-state level, acted on at its rising edge
//   slot      in   save slot, sampled when a request is accepted
//   nvram_we  in   state-RAM write strobe (dirty tracking)
//   sd_ack    in   HPS acknowledge, high for the whole sector transfer
//   sd_lba    out  sector address {zero pad, slot, index}
//   sd_rd     out  sector read request
//   sd_wr     out  sector write request
//   busy      out  operation in progress
//   loading   out  load in progress (core held in reset)
//   done      out  one-cycle completion pulse, success or abort
//   err       out  sticky: last operation aborted on timeout
//
// Build option: define BK_DIRTY_EN to track state-RAM writes and skip saves
// when nothing has changed since the last successful load or save.
// -----------------------------------------------------------------------------
module bk_sector_ctrl
   import bk_pkg::*;
#(
   parameter int SECTORS = BK_SECTORS_DEF,
   parameter int SLOT_W  = BK_SLOT_W_DEF,
   parameter int TMO_W   = BK_TMO_W_DEF
) (
   input  logic              clk_sys,
   input  logic              RESET_n,
   input  logic              bk_ena,
   input  logic              load_req,
   input  logic              save_req,
   input  logic [SLOT_W-1:0] slot,
   input  logic              nvram_we,
   input  logic              sd_ack,
   output logic [31:0]       sd_lba,
   output logic              sd_rd,
   output logic              sd_wr,
   output logic              busy,
   output logic              loading,
   output logic              done,
   output logic              err
);

   localparam int IDX_W = $clog2(SECTORS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SECTORS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   bk_state_t         state;
   logic              load_q;
   logic              save_q;
   logic              ack_q;
   logic              armed;
   logic [SLOT_W-1:0] slot_q;
   logic [IDX_W-1:0]  idx;

   logic load_rise;
   logic save_rise;
   logic ack_rise;
   logic ack_fall;
   logic accept_load;
   logic accept_save;
   logic skip_save;
   logic skip;
   logic tmo_clr;
   logic tmo_en;
   logic tmo_expired;

   // The index sits in the low bits and the slot directly above it; the index
   // never exceeds SECTORS-1, so stepping it can never disturb the slot field.
   function automatic logic [31:0] make_lba(input logic [SLOT_W-1:0] s,
                                            input logic [IDX_W-1:0]  i);
      logic [31:0] r;
      r = '0;
      r[IDX_W +: SLOT_W] = s;
      r[IDX_W-1:0]       = i;
      return r;
   endfunction

   // Edge registers reset to zero would make a level held through reset look
   // like a fresh edge in the first cycle after release; armed masks that
   // cycle so only genuine post-reset edges start an operation.
   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         load_q <= 1'b0;
         save_q <= 1'b0;
         ack_q  <= 1'b0;
         armed  <= 1'b0;
      end else begin
         load_q <= load_req;
         save_q <= save_req;
         ack_q  <= sd_ack;
         armed  <= 1'b1;
      end
   end

   assign load_rise = load_req & ~load_q;
   assign save_rise = save_req & ~save_q;
   assign ack_rise  = sd_ack & ~ack_q;
   assign ack_fall  = ~sd_ack & ack_q;

   // Edges outside IDLE are simply lost; a simultaneous load beats save.
   assign accept_load = (state == ST_IDLE) & bk_ena & armed & load_rise;
   assign accept_save = (state == ST_IDLE) & bk_ena & armed & save_rise & ~load_rise;

`ifdef BK_DIRTY_EN
   logic dirty;

   // A write in the same cycle as FIN keeps the image marked as changed.
   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         dirty <= 1'b0;
      end else if (nvram_we) begin
         dirty <= 1'b1;
      end else if ((state == ST_FIN) && !err) begin
         dirty <= 1'b0;
      end
   end

   assign skip_save = ~dirty;
`else
   logic unused_nvram_we;
   assign unused_nvram_we = nvram_we;
   assign skip_save       = 1'b0;
`endif

   assign skip = accept_save & skip_save;

   // Restart the acknowledge timer whenever REQ or XFER is entered.
   assign tmo_clr = ((accept_load | accept_save) & ~skip)
                  | ((state == ST_REQ) & ack_rise)
                  | (state == ST_NEXT);
   assign tmo_en  = (state == ST_REQ) | (state == ST_XFER);

   bk_timeout #(
      .TMO_W (TMO_W)
   ) u_timeout (
      .clk_sys (clk_sys),
      .RESET_n (RESET_n),
      .clr     (tmo_clr),
      .en      (tmo_en),
      .expired (tmo_expired)
   );

   // Main sequencer. An acknowledge edge takes priority over a timeout that
   // expires in the same cycle, since the transfer did in fact progress.
   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         state   <= ST_IDLE;
         sd_lba  <= '0;
         sd_rd   <= 1'b0;
         sd_wr   <= 1'b0;
         busy    <= 1'b0;
         loading <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         slot_q  <= '0;
         idx     <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (accept_load || accept_save) begin
                  slot_q  <= slot;
                  idx     <= '0;
                  err     <= 1'b0;
                  busy    <= 1'b1;
                  loading <= accept_load;
                  if (skip) begin
                     state <= ST_FIN;
                  end else begin
                     sd_lba <= make_lba(slot, '0);
                     sd_rd  <= accept_load;
                     sd_wr  <= ~accept_load;
                     state  <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (ack_rise) begin
                  sd_rd <= 1'b0;
                  sd_wr <= 1'b0;
                  state <= ST_XFER;
               end else if (tmo_expired) begin
                  sd_rd <= 1'b0;
                  sd_wr <= 1'b0;
                  err   <= 1'b1;
                  state <= ST_FIN;
               end
            end
            ST_XFER: begin
               if (ack_fall) begin
                  state <= (idx == IDX_LAST) ? ST_FIN : ST_NEXT;
               end else if (tmo_expired) begin
                  err   <= 1'b1;
                  state <= ST_FIN;
               end
            end
            ST_NEXT: begin
               idx    <= idx + IDX_ONE;
               sd_lba <= make_lba(slot_q, idx + IDX_ONE);
               sd_rd  <= loading;
               sd_wr  <= ~loading;
               state  <= ST_REQ;
            end
            ST_FIN: begin
               busy    <= 1'b0;
               loading <= 1'b0;
               done    <= 1'b1;
               state   <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bk_sector_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bk_sector_ctrl
// Scoreboard bench: stimulus pushes the expected sector requests and
// completion records; an independent monitor pops and compares them as the
// controller presents requests and done pulses. A responder process plays
// the HPS side with random (or fixed) acknowledge delay and width.
// -----------------------------------------------------------------------------
module tb_bk_sector_ctrl;

   localparam int SECTORS = 64;
   localparam int SLOT_W  = 2;
   localparam int TMO_W   = 4;

`ifdef BK_DIRTY_EN
   localparam bit DIRTY_EN = 1'b1;
`else
   localparam bit DIRTY_EN = 1'b0;
`endif

   logic              clk_sys  = 1'b0;
   logic              RESET_n  = 1'b0;
   logic              bk_ena   = 1'b0;
   logic              load_req = 1'b0;
   logic              save_req = 1'b0;
   logic [SLOT_W-1:0] slot     = '0;
   logic              nvram_we = 1'b0;
   logic              sd_ack   = 1'b0;
   logic [31:0]       sd_lba;
   logic              sd_rd;
   logic              sd_wr;
   logic              busy;
   logic              loading;
   logic              done;
   logic              err;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] lba;
      logic        is_read;
   } sect_t;

   sect_t exp_sect[$];
   logic  exp_done[$];

   int sect_seen   = 0;
   int done_seen   = 0;
   int rd_run      = 0;
   int last_rd_run = 0;
   bit req_prev    = 1'b0;
   bit ack_en      = 1'b1;
   bit ack_fixed   = 1'b0;
   bit dirty_m     = 1'b0;

   always #5 clk_sys = ~clk_sys;

   bk_sector_ctrl #(
      .SECTORS (SECTORS),
      .SLOT_W  (SLOT_W),
      .TMO_W   (TMO_W)
   ) dut (
      .clk_sys  (clk_sys),
      .RESET_n  (RESET_n),
      .bk_ena   (bk_ena),
      .load_req (load_req),
      .save_req (save_req),
      .slot     (slot),
      .nvram_we (nvram_we),
      .sd_ack   (sd_ack),
      .sd_lba   (sd_lba),
      .sd_rd    (sd_rd),
      .sd_wr    (sd_wr),
      .busy     (busy),
      .loading  (loading),
      .done     (done),
      .err      (err)
   );

   task automatic check_output(input string name, input logic [63:0] act,
                               input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: an accepted operation moves every sector of the slot in
   // ascending order and finishes cleanly; a save of an unchanged image (dirty
   // build only) finishes without touching the card.
   task automatic expect_op(input bit is_load, input int s);
      if (!is_load && DIRTY_EN && !dirty_m) begin
         exp_done.push_back(1'b0);
      end else begin
         for (int i = 0; i < SECTORS; i++) begin
            sect_t e;
            e.lba     = 32'(s * SECTORS + i);
            e.is_read = is_load;
            exp_sect.push_back(e);
         end
         exp_done.push_back(1'b0);
         dirty_m = 1'b0;
      end
   endtask

   // Timed-out load: the first request appears, nothing acknowledges it.
   task automatic expect_timeout(input int s);
      sect_t e;
      e.lba     = 32'(s * SECTORS);
      e.is_read = 1'b1;
      exp_sect.push_back(e);
      exp_done.push_back(1'b1);
   endtask

   task automatic apply_stimulus(input bit do_load, input bit do_save,
                                 input logic [SLOT_W-1:0] s);
      @(negedge clk_sys);
      slot = s;
      if (do_load) load_req = 1'b1;
      if (do_save) save_req = 1'b1;
      repeat (2) @(negedge clk_sys);
      load_req = 1'b0;
      save_req = 1'b0;
   endtask

   task automatic pulse_nvram_we();
      @(negedge clk_sys);
      nvram_we = 1'b1;
      @(negedge clk_sys);
      nvram_we = 1'b0;
      dirty_m  = 1'b1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic wait_done(input int target, input int budget);
      int k;
      k = 0;
      while (done_seen < target && k < budget) begin
         @(negedge clk_sys);
         k++;
      end
      check_output("op_completes", 64'(done_seen >= target), 64'(1));
   endtask

   // Monitor: pops the scoreboard on each new sector request and done pulse.
   always @(negedge clk_sys) begin
      sect_t e;
      logic  e_err;
      logic  rq;
      rq = sd_rd | sd_wr;
      if (sd_rd) begin
         rd_run++;
      end else begin
         if (rd_run != 0) last_rd_run = rd_run;
         rd_run = 0;
      end
      if (rq && !req_prev) begin
         sect_seen++;
         if (exp_sect.size() == 0) begin
            check_output("sector_expected", 64'(exp_sect.size() > 0), 64'(1));
         end else begin
            e = exp_sect.pop_front();
            check_output("sector", 64'({sd_lba, sd_rd, sd_wr, loading, busy}),
                         64'({e.lba, e.is_read, ~e.is_read, e.is_read, 1'b1}));
         end
      end
      req_prev = rq;
      if (done) begin
         done_seen++;
         if (exp_done.size() == 0) begin
            check_output("done_expected", 64'(exp_done.size() > 0), 64'(1));
         end else begin
            e_err = exp_done.pop_front();
            check_output("done", 64'({err, busy, loading, sd_rd, sd_wr}),
                         64'({e_err, 4'b0000}));
         end
      end
   end

   // HPS responder: acknowledge each new request after a delay, for a width.
   initial begin
      forever begin
         @(negedge clk_sys);
         if (ack_en && RESET_n && (sd_rd || sd_wr)) begin
            int d;
            int w;
            d = ack_fixed ? 3  : int'($urandom_range(0, 6));
            w = ack_fixed ? 10 : int'($urandom_range(1, 10));
            repeat (d) @(negedge clk_sys);
            sd_ack = 1'b1;
            repeat (w) @(negedge clk_sys);
            sd_ack = 1'b0;
         end
      end
   end

   initial begin
      int base;
      int dcount;
      int k;

      // Reset state
      wait_cycles(3);
      check_output("reset_outputs",
                   64'({sd_lba, sd_rd, sd_wr, busy, loading, done, err}), 64'(0));
      RESET_n = 1'b1;
      bk_ena  = 1'b1;
      wait_cycles(3);
      check_output("idle_busy", 64'(busy), 64'(0));

      // Load slot 2 with fixed ack timing
      $display("[TB] load slot 2");
      ack_fixed = 1'b1;
      expect_op(1'b1, 2);
      apply_stimulus(1'b1, 1'b0, 2'd2);
      wait_done(1, 3000);
      ack_fixed = 1'b0;
      check_output("load_final_lba", 64'(sd_lba), 64'(191));

      // Save slot 3: last address is the top of the slot, no carry
      $display("[TB] save slot 3");
      pulse_nvram_we();
      expect_op(1'b0, 3);
      apply_stimulus(1'b0, 1'b1, 2'd3);
      wait_done(2, 3000);
      wait_cycles(5);
      check_output("save_final_lba", 64'(sd_lba), 64'(255));

      // Save without intervening state-RAM writes, then with one
      $display("[TB] dirty tracking saves");
      expect_op(1'b0, 1);
      apply_stimulus(1'b0, 1'b1, 2'd1);
      wait_done(3, 3000);
      pulse_nvram_we();
      expect_op(1'b0, 1);
      apply_stimulus(1'b0, 1'b1, 2'd1);
      wait_done(4, 3000);

      // Simultaneous load and save edges, then a save edge while busy
      $display("[TB] load/save collision");
      pulse_nvram_we();
      expect_op(1'b1, 0);
      apply_stimulus(1'b1, 1'b1, 2'd0);
      wait_cycles(40);
      check_output("busy_during_load", 64'(busy), 64'(1));
      apply_stimulus(1'b0, 1'b1, 2'd3);
      wait_done(5, 3000);
      wait_cycles(40);
      check_output("idle_after_done", 64'(busy), 64'(0));

      // Requests with the image unmounted are discarded
      $display("[TB] bk_ena low");
      bk_ena = 1'b0;
      apply_stimulus(1'b1, 1'b0, 2'd1);
      wait_cycles(20);
      check_output("bk_ena_blocks", 64'({busy, sd_rd, sd_wr}), 64'(0));
      bk_ena = 1'b1;
      wait_cycles(5);

      // Acknowledge never arrives
      $display("[TB] timeout");
      ack_en = 1'b0;
      expect_timeout(1);
      apply_stimulus(1'b1, 1'b0, 2'd1);
      wait_done(6, 200);
      check_output("tmo_rd_cycles", 64'(last_rd_run), 64'(15));
      wait_cycles(5);
      check_output("err_sticky", 64'({err, busy, sd_rd}), 64'(3'b100));
      ack_en = 1'b1;

      // Randomized operations
      $display("[TB] random operations");
      dcount = 6;
      for (int n = 0; n < 6; n++) begin
         bit is_load;
         int s;
         is_load = 1'($urandom_range(0, 1));
         s       = int'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) pulse_nvram_we();
         expect_op(is_load, s);
         apply_stimulus(is_load, ~is_load, SLOT_W'(s));
         dcount++;
         wait_done(dcount, 3000);
         wait_cycles(int'($urandom_range(2, 8)));
      end

      // Reset during sector 5 of a save, request level held through release
      $display("[TB] reset mid-transfer");
      pulse_nvram_we();
      expect_op(1'b0, 2);
      base = sect_seen;
      @(negedge clk_sys);
      slot     = 2'd2;
      save_req = 1'b1;
      k = 0;
      while (sect_seen < base + 6 && k < 2000) begin
         @(negedge clk_sys);
         k++;
      end
      check_output("reached_sector5", 64'(sect_seen >= base + 6), 64'(1));
      @(posedge clk_sys);
      #2;
      RESET_n = 1'b0;
      exp_sect.delete();
      exp_done.delete();
      dirty_m = 1'b0;
      #1;
      check_output("reset_async_outputs",
                   64'({sd_lba, sd_rd, sd_wr, busy, loading, done, err}), 64'(0));
      wait_cycles(3);
      RESET_n = 1'b1;
      wait_cycles(20);
      check_output("no_op_after_reset", 64'({busy, sd_rd, sd_wr}), 64'(0));
      check_output("no_done_on_reset", 64'(done_seen), 64'(dcount));
      save_req = 1'b0;
      wait_cycles(5);

      // Normal operation resumes
      $display("[TB] load after reset");
      expect_op(1'b1, 3);
      apply_stimulus(1'b1, 1'b0, 2'd3);
      wait_done(dcount + 1, 3000);
      wait_cycles(20);

      check_output("sector_queue_empty", 64'(exp_sect.size()), 64'(0));
      check_output("done_queue_empty", 64'(exp_done.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bk_sector_ctrl.md
BK_SECTOR_CTRL -- requirements
Module: bk_sector_ctrl

Interface
REQ-001 Parameters SHALL be: SECTORS, default 64, sectors per save slot (power of two, ≥2); SLOT_W, default 2, slot-select width; TMO_W, default 24, ack-timeout counter width.
REQ-002 clk_sys  in  1  system clock, all logic on posedge.
REQ-003 RESET_n  in  1  asynchronous active-low reset.
REQ-004 bk_ena  in  1  writable save image mounted; low blocks new requests.
REQ-005 load_req  in  1  load-state level (menu bit); acted on at its rising edge only.
REQ-006 save_req  in  1  save-state level; acted on at its rising edge only.
REQ-007 slot  in  SLOT_W  save slot, sampled at request acceptance.
REQ-008 nvram_we  in  1  state-RAM write strobe from the core (dirty tracking).
REQ-009 sd_ack  in  1  HPS sector acknowledge, high for the whole transfer.
REQ-010 sd_lba  out  32  sector address.
REQ-011 sd_rd / sd_wr  out  1 each  sector read / write request.
REQ-012 busy  out  1  operation in progress.
REQ-013 loading  out  1  load in progress; the core is held in reset while high.
REQ-014 done  out  1  one-cycle pulse on completion, success or abort.
REQ-015 err  out  1  sticky: last operation aborted on timeout.

Function
REQ-016 Rising edges SHALL be found by comparing each input with its value registered on the previous cycle; an edge is accepted only in IDLE with bk_ena=1, otherwise it is discarded and never queued.
REQ-017 If load and save edges occur in the same cycle, load SHALL win and the save edge SHALL be discarded.
REQ-018 FSM states SHALL be IDLE, REQ, XFER, NEXT, FIN.
REQ-019 On acceptance: slot latched, sector index cleared, err cleared, busy=1, loading=load, sd_lba=slot*SECTORS+0, and the next state is REQ, with sd_rd=load or sd_wr=~load asserted in the same cycle.
REQ-020 REQ: on sd_ack rising edge, sd_rd and sd_wr SHALL clear and the FSM SHALL go to XFER.
REQ-021 XFER: on sd_ack falling edge, if index=SECTORS-1 go to FIN, else go to NEXT.
REQ-022 NEXT: index+1 and sd_lba+1, re-assert the same request, go to REQ, all within one cycle.
REQ-023 FIN: busy=0, loading=0, done=1 for one cycle, go to IDLE.
REQ-024 The full sd_lba is {zero-pad, slot, index} with index log2(SECTORS) bits; the index SHALL never carry into the slot field.
REQ-025 A timeout counter SHALL clear on every REQ or XFER entry and count each cycle in REQ/XFER; when it reaches all-ones: clear sd_rd/sd_wr, set err, go to FIN.
REQ-026 sd_ack high while in IDLE SHALL be ignored and SHALL NOT be treated as an edge on the next acceptance.
REQ-027 sd_lba SHALL hold its last value in IDLE.

Reset
REQ-028 On RESET_n low, immediately: FSM=IDLE, sd_lba=0, sd_rd=sd_wr=busy=loading=done=err=0, edge registers=0, index=0, timeout=0, dirty=0.
REQ-029 Reset mid-transfer SHALL abandon the operation without any done pulse.
REQ-030 A request level already high when reset releases SHALL NOT trigger an operation.

Configuration
REQ-031 Macro BK_DIRTY_EN. When defined: dirty sets on nvram_we and clears at FIN of a successful save or load. A save edge with dirty=0 issues no SD request; it goes IDLE→FIN, pulsing done with err=0. nvram_we in the same cycle as FIN of a save leaves dirty=1.
REQ-032 When BK_DIRTY_EN is undefined: nvram_we is ignored, no dirty register exists, and every save transfers SECTORS sectors.

Structure
REQ-033 Package bk_pkg SHALL hold the FSM state enum and the default SECTORS/SLOT_W/TMO_W constants.
REQ-034 One sub-module, bk_timeout (clear/enable/expire counter), SHALL implement REQ-025; all other logic stays in bk_sector_ctrl.

Verification
REQ-035 Load, slot=2, ack 3 cycles after each request and 10 cycles wide: sd_lba steps 128..191, sd_rd only, loading high throughout, one done pulse, err=0.
REQ-036 Save, slot=3, SECTORS=64: sd_wr only, final sd_lba=255, no lba carry, done once.
REQ-037 Load and save edges in the same cycle: load only. A save edge while busy: ignored, and nothing runs after done.
REQ-038 TMO_W=4 with sd_ack never asserted: abort after 15 cycles in REQ, sd_rd low, err=1, done pulse, busy=0.
REQ-039 RESET_n low during sector 5 of a save: all outputs 0 at once, no done. With save_req still high at release: stays IDLE.
REQ-040 BK_DIRTY_EN: save with no prior nvram_we gives done and zero sd_wr pulses. After one nvram_we, the save transfers 64 sectors and dirty clears.
